// File: rtl/segasys1_sprcoll_ram.sv
`default_nettype none
// ============================================================================
//  Module   : segasys1_sprcoll_ram
//  Purpose  : Sprite collision recorder. Renderer hits are queued and written
//             into a 1024x1 collision RAM that the CPU reads and clears. A
//             summary flag and a sticky queue-overflow bit are kept alongside.
//  Ports    : VCLKx8 / RESET_N       - clock, async active-low reset
//             sprcoll / sprcoll_ad   - collision strobe and address
//             cpu_cs_ram/cpu_cs_flag - CPU selects (RAM window / flag reg)
//             cpu_rd / cpu_wr        - CPU strobes (any write clears)
//             cpu_ad                 - CPU address within the RAM window
//             cpu_dout               - registered read data
//             coll_flag / q_ovf      - summary flag, sticky overflow
//  Revision : 1.0  initial release
// ============================================================================
module segasys1_sprcoll_ram #(
  parameter int QDEPTH = 4,
  parameter int AW     = 10
) (
  input  logic          VCLKx8,
  input  logic          RESET_N,
  input  logic          sprcoll,
  input  logic [AW-1:0] sprcoll_ad,
  input  logic          cpu_cs_ram,
  input  logic          cpu_cs_flag,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_ad,
  output logic [7:0]    cpu_dout,
  output logic          coll_flag,
  output logic          q_ovf
);

  localparam int QW = $clog2(QDEPTH);
  localparam int PW = QW + 1;
  localparam int NWORDS = 1 << AW;
  localparam logic [QW-1:0] QONE = 1;
  localparam logic [PW-1:0] PONE = 1;
  localparam logic [AW-1:0] AONE = 1;

  // Collision RAM (no reset; cleared by the sequencer after reset release)
  logic ram_mem [NWORDS];

  logic          clr_busy_q, clr_busy_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW-1:0] qaddr_q [QDEPTH];
  logic [AW-1:0] qaddr_d [QDEPTH];
  logic [QDEPTH-1:0] qvld_q, qvld_d, qvld_inv;
  logic [7:0]    dout_q, dout_d;
  logic          coll_flag_q, coll_flag_d;
  logic          q_ovf_q, q_ovf_d;

  logic          ram_op_wr, ram_op_rd, flag_wr, flag_rd;
  logic          q_empty, q_full, drain_go, coalesce, push, ovf_evt, hit;
  logic [QW-1:0] head, tail, newest;
  logic          ram_we, ram_wd;
  logic [AW-1:0] ram_wa;

  always_comb begin
    // Flag select has priority over the RAM window; write beats read.
    ram_op_wr = cpu_cs_ram & ~cpu_cs_flag & cpu_wr;
    ram_op_rd = cpu_cs_ram & ~cpu_cs_flag & cpu_rd & ~cpu_wr;
    flag_wr   = cpu_cs_flag & cpu_wr;
    flag_rd   = cpu_cs_flag & cpu_rd & ~cpu_wr;

    head    = rp_q[QW-1:0];
    tail    = wp_q[QW-1:0];
    newest  = tail - QONE;
    q_empty = (wp_q == rp_q);
    q_full  = (wp_q[QW] != rp_q[QW]) && (tail == head);

    // Drain only when nothing of higher priority owns the RAM port.
    drain_go = ~clr_busy_q & ~ram_op_wr & ~ram_op_rd & ~q_empty;

    // Read bypass: hits still waiting in the queue count as recorded.
    hit = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (qvld_q[i] && (qaddr_q[i] == cpu_ad)) hit = 1'b1;
    end

    // A CPU clear kills already-queued copies of the address; the slot
    // itself stays occupied and is later popped without a RAM write.
    qvld_inv = qvld_q;
    if (ram_op_wr) begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (qaddr_q[i] == cpu_ad) qvld_inv[i] = 1'b0;
      end
    end

    coalesce = ~q_empty & qvld_inv[newest] & (qaddr_q[newest] == sprcoll_ad);
    // A drain in the same cycle frees a slot before the push lands.
    push     = sprcoll & ~coalesce & ~(q_full & ~drain_go);
    ovf_evt  = sprcoll & ~coalesce & q_full & ~drain_go;

    qaddr_d = qaddr_q;
    qvld_d  = qvld_inv;
    rp_d    = rp_q;
    wp_d    = wp_q;
    if (drain_go) begin
      qvld_d[head] = 1'b0;
      rp_d         = rp_q + PONE;
    end
    if (push) begin
      qaddr_d[tail] = sprcoll_ad;
      qvld_d[tail]  = 1'b1;
      wp_d          = wp_q + PONE;
    end

    // Single RAM write port, fixed priority.
    ram_we = 1'b0;
    ram_wa = cpu_ad;
    ram_wd = 1'b0;
    if (clr_busy_q) begin
      ram_we = 1'b1;
      ram_wa = clr_cnt_q;
    end else if (ram_op_wr) begin
      ram_we = 1'b1;
    end else if (drain_go && qvld_q[head]) begin
      ram_we = 1'b1;
      ram_wa = qaddr_q[head];
      ram_wd = 1'b1;
    end

    clr_busy_d = clr_busy_q;
    clr_cnt_d  = clr_cnt_q;
    if (clr_busy_q) begin
      clr_cnt_d = clr_cnt_q + AONE;
      if (clr_cnt_q == {AW{1'b1}}) clr_busy_d = 1'b0;
    end

    dout_d = dout_q;
    if (ram_op_rd) begin
      dout_d = {7'h7F, ~clr_busy_q & (ram_mem[cpu_ad] | hit)};
    end else if (flag_rd) begin
      dout_d = {6'h3F, q_ovf_q, coll_flag_q};
    end

    coll_flag_d = (coll_flag_q & ~flag_wr) | sprcoll;
    q_ovf_d     = (q_ovf_q & ~flag_wr) | ovf_evt;
  end

  always_ff @(posedge VCLKx8) begin
    if (ram_we) ram_mem[ram_wa] <= ram_wd;
  end

  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      clr_busy_q  <= 1'b1;
      clr_cnt_q   <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      qvld_q      <= '0;
      dout_q      <= 8'h00;
      coll_flag_q <= 1'b0;
      q_ovf_q     <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) qaddr_q[i] <= '0;
    end else begin
      clr_busy_q  <= clr_busy_d;
      clr_cnt_q   <= clr_cnt_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      qvld_q      <= qvld_d;
      dout_q      <= dout_d;
      coll_flag_q <= coll_flag_d;
      q_ovf_q     <= q_ovf_d;
      for (int i = 0; i < QDEPTH; i++) qaddr_q[i] <= qaddr_d[i];
    end
  end

  assign cpu_dout  = dout_q;
  assign coll_flag = coll_flag_q;
  assign q_ovf     = q_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_segasys1_sprcoll_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segasys1_sprcoll_ram
//  Purpose  : Directed self-checking bench for segasys1_sprcoll_ram.
//  Revision : 1.0  initial release
// ============================================================================
module tb_segasys1_sprcoll_ram;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sprcoll;
  logic [9:0] sprcoll_ad;
  logic       cs_ram, cs_flag, rd, wr;
  logic [9:0] cpu_ad;
  logic [7:0] cpu_dout;
  logic       coll_flag, q_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  segasys1_sprcoll_ram #(.QDEPTH(4), .AW(10)) dut (
    .VCLKx8      (clk),
    .RESET_N     (rst_n),
    .sprcoll     (sprcoll),
    .sprcoll_ad  (sprcoll_ad),
    .cpu_cs_ram  (cs_ram),
    .cpu_cs_flag (cs_flag),
    .cpu_rd      (rd),
    .cpu_wr      (wr),
    .cpu_ad      (cpu_ad),
    .cpu_dout    (cpu_dout),
    .coll_flag   (coll_flag),
    .q_ovf       (q_ovf)
  );

  // Stimulus helpers: inputs change and outputs are sampled on negedges.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    sprcoll = 0; cs_ram = 0; cs_flag = 0; rd = 0; wr = 0;
  endtask

  task automatic do_read(input logic [9:0] a);
    cs_ram = 1; rd = 1; cpu_ad = a; step();
    cs_ram = 0; rd = 0;
  endtask

  task automatic do_flag_read();
    cs_flag = 1; rd = 1; step();
    cs_flag = 0; rd = 0;
  endtask

  task automatic do_flag_write();
    cs_flag = 1; wr = 1; step();
    cs_flag = 0; wr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; idle(); step(3);
    rst_n = 1; step(1030);
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); sprcoll_ad = '0; cpu_ad = '0;
    #12;
    n_checks++; if (cpu_dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", cpu_dout); else n_pass++;
    n_checks++; if (coll_flag !== 1'b0) $display("FAIL reset_flag got=%b exp=0", coll_flag); else n_pass++;
    n_checks++; if (q_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", q_ovf); else n_pass++;
    step(2);
    rst_n = 1; step(1030);
    do_read(10'h000);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL reset_rd000 got=%h exp=FE", cpu_dout); else n_pass++;
    do_read(10'h3FF);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL reset_rd3ff got=%h exp=FE", cpu_dout); else n_pass++;
    do_flag_read();
    n_checks++; if (cpu_dout !== 8'hFC) $display("FAIL reset_flagrd got=%h exp=FC", cpu_dout); else n_pass++;
  endtask

  task automatic test_hit();
    sprcoll = 1; sprcoll_ad = 10'h155; step();
    sprcoll = 0; step();
    do_read(10'h155);
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL hit_rd155 got=%h exp=FF", cpu_dout); else n_pass++;
    n_checks++; if (coll_flag !== 1'b1) $display("FAIL hit_flag got=%b exp=1", coll_flag); else n_pass++;
    do_read(10'h156);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL hit_rd156 got=%h exp=FE", cpu_dout); else n_pass++;
  endtask

  task automatic test_bypass();
    logic [9:0] addrs [3];
    addrs[0] = 10'h010; addrs[1] = 10'h020; addrs[2] = 10'h030;
    cs_ram = 1; rd = 1; cpu_ad = 10'h3F0;
    sprcoll = 1; sprcoll_ad = addrs[0]; step();
    for (int i = 0; i < 3; i++) begin
      cpu_ad = addrs[i];
      if (i < 2) sprcoll_ad = addrs[i+1]; else sprcoll = 0;
      step();
      n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL bypass_rd%0d got=%h exp=FF", i, cpu_dout); else n_pass++;
    end
    idle(); step(3);
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i]);
      n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL bypass_ram%0d got=%h exp=FF", i, cpu_dout); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [9:0] a;
    cs_ram = 1; rd = 1; cpu_ad = 10'h3F0;
    for (int i = 0; i < 6; i++) begin
      sprcoll = 1; a = 10'h100 + 10'(i); sprcoll_ad = a; step();
    end
    idle();
    n_checks++; if (q_ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", q_ovf); else n_pass++;
    step(6);
    for (int i = 0; i < 6; i++) begin
      a = 10'h100 + 10'(i);
      do_read(a);
      n_checks++;
      if (cpu_dout !== ((i < 4) ? 8'hFF : 8'hFE))
        $display("FAIL ovf_rd%0d got=%h exp=%h", i, cpu_dout, (i < 4) ? 8'hFF : 8'hFE);
      else n_pass++;
    end
    do_flag_read();
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL ovf_flagrd got=%h exp=FF", cpu_dout); else n_pass++;
    do_flag_write();
    do_flag_read();
    n_checks++; if (cpu_dout !== 8'hFC) $display("FAIL ovf_flagclr got=%h exp=FC", cpu_dout); else n_pass++;
  endtask

  task automatic test_coalesce();
    cs_ram = 1; rd = 1; cpu_ad = 10'h3F0;
    sprcoll = 1; sprcoll_ad = 10'h200; step(5);
    for (int i = 1; i < 4; i++) begin
      sprcoll_ad = 10'h200 + 10'(i); step();
    end
    n_checks++; if (q_ovf !== 1'b0) $display("FAIL coal_noovf got=%b exp=0", q_ovf); else n_pass++;
    sprcoll_ad = 10'h204; step();
    n_checks++; if (q_ovf !== 1'b1) $display("FAIL coal_ovf got=%b exp=1", q_ovf); else n_pass++;
    idle(); step(6);
    do_read(10'h200);
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL coal_rd200 got=%h exp=FF", cpu_dout); else n_pass++;
    do_read(10'h203);
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL coal_rd203 got=%h exp=FF", cpu_dout); else n_pass++;
    do_read(10'h204);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL coal_rd204 got=%h exp=FE", cpu_dout); else n_pass++;
  endtask

  task automatic test_flag_set_wins();
    cs_flag = 1; wr = 1; sprcoll = 1; sprcoll_ad = 10'h2A0; step();
    idle();
    n_checks++; if (coll_flag !== 1'b1) $display("FAIL flagwr_setwins got=%b exp=1", coll_flag); else n_pass++;
    n_checks++; if (q_ovf !== 1'b0) $display("FAIL flagwr_ovfclr got=%b exp=0", q_ovf); else n_pass++;
    do_flag_write();
    n_checks++; if (coll_flag !== 1'b0) $display("FAIL flagwr_clr got=%b exp=0", coll_flag); else n_pass++;
  endtask

  task automatic test_clear_races();
    // clear and hit to the same address in one cycle: hit survives
    cs_ram = 1; wr = 1; cpu_ad = 10'h080; sprcoll = 1; sprcoll_ad = 10'h080; step();
    idle(); step(3);
    do_read(10'h080);
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL race_rd080 got=%h exp=FF", cpu_dout); else n_pass++;
    // clear of an address already waiting in the queue
    cs_ram = 1; rd = 1; cpu_ad = 10'h3F0; sprcoll = 1; sprcoll_ad = 10'h090; step();
    sprcoll = 0; rd = 0; wr = 1; cpu_ad = 10'h090; step();
    idle(); step(3);
    do_read(10'h090);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL race_rd090 got=%h exp=FE", cpu_dout); else n_pass++;
    // plain clear of a recorded bit
    cs_ram = 1; wr = 1; cpu_ad = 10'h155; step();
    idle();
    do_read(10'h155);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL clr_rd155 got=%h exp=FE", cpu_dout); else n_pass++;
    // read and write together: write wins, read data held
    cs_ram = 1; rd = 1; wr = 1; cpu_ad = 10'h010; step();
    idle();
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL rdwr_hold got=%h exp=FE", cpu_dout); else n_pass++;
    do_read(10'h010);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL rdwr_clr got=%h exp=FE", cpu_dout); else n_pass++;
    // both selects: flag register wins, RAM untouched
    n_checks++; if (coll_flag !== 1'b1) $display("FAIL bothsel_pre got=%b exp=1", coll_flag); else n_pass++;
    cs_ram = 1; cs_flag = 1; wr = 1; cpu_ad = 10'h020; step();
    idle();
    n_checks++; if (coll_flag !== 1'b0) $display("FAIL bothsel_flag got=%b exp=0", coll_flag); else n_pass++;
    do_read(10'h020);
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL bothsel_rd020 got=%h exp=FF", cpu_dout); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    logic [9:0] a;
    cs_ram = 1; rd = 1; cpu_ad = 10'h300;
    for (int i = 0; i < 5; i++) begin
      sprcoll = 1; a = 10'h300 + 10'(i); sprcoll_ad = a; step();
    end
    idle();
    n_checks++; if (cpu_dout !== 8'hFF) $display("FAIL mid_pre_dout got=%h exp=FF", cpu_dout); else n_pass++;
    step();
    #2 rst_n = 0;
    #1;
    n_checks++; if (cpu_dout !== 8'h00) $display("FAIL mid_rst_dout got=%h exp=00", cpu_dout); else n_pass++;
    n_checks++; if (coll_flag !== 1'b0) $display("FAIL mid_rst_flag got=%b exp=0", coll_flag); else n_pass++;
    n_checks++; if (q_ovf !== 1'b0) $display("FAIL mid_rst_ovf got=%b exp=0", q_ovf); else n_pass++;
    step(2);
    rst_n = 1; step(1030);
    do_read(10'h300);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL mid_rd300 got=%h exp=FE", cpu_dout); else n_pass++;
    do_read(10'h302);
    n_checks++; if (cpu_dout !== 8'hFE) $display("FAIL mid_rd302 got=%h exp=FE", cpu_dout); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_hit();
    test_bypass();
    test_overflow();
    test_coalesce();
    test_flag_set_wins();
    test_clear_races();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segasys1_sprcoll_ram.md
Name: segasys1_sprcoll_ram

Overview:
- Consumes the sprite renderer's collision strobe (`sprcoll`) and collision address (`sprcoll_ad`).
- Records each hit in a 1024x1 collision RAM and a summary flag, both of which the main CPU reads and clears.
- A small pending queue decouples renderer bursts from CPU accesses, because both share the one RAM port.
- Sits between the sprite stage and the CPU bus decoder.

Parameters:
- QDEPTH, 4: pending-set queue depth (power of 2, 2..8).
- AW, 10: collision address width (1024 entries).

Ports:
- VCLKx8  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- sprcoll  in  1  one-cycle collision strobe from the sprite stage.
- sprcoll_ad  in  AW  collision address, valid with `sprcoll`.
- cpu_cs_ram  in  1  CPU select, collision RAM window.
- cpu_cs_flag  in  1  CPU select, summary flag register.
- cpu_rd  in  1  one-cycle read strobe, qualified by a select.
- cpu_wr  in  1  one-cycle write strobe, qualified by a select (write data ignored: any write clears).
- cpu_ad  in  AW  CPU address within the RAM window.
- cpu_dout  out  8  read data.
- coll_flag  out  1  summary flag, also routed to the sound/IO logic.
- q_ovf  out  1  sticky queue-overflow indicator.

Behaviour:
- Reset (async, RESET_N=0):
  - RAM contents cleared (clear sequencer, see below).
  - Queue emptied.
  - cpu_dout=8'h00, coll_flag=0, q_ovf=0.
- Reset clear sequencer:
  - On RESET_N deassert, clears all 1024 RAM bits, one per cycle, over 1024 cycles.
  - During the sequence, CPU RAM reads return 0.
  - During the sequence, sprcoll still enqueues and coll_flag still sets; the queue does not drain until the sequence finishes.
- Enqueue:
  - On sprcoll=1, push sprcoll_ad.
  - Coalesce: skip the push if the address equals the newest valid entry.
  - If the queue is full and the address is not coalesced: drop it and set q_ovf.
  - coll_flag sets on every sprcoll pulse, dropped or not.
- RAM port arbitration, one operation per cycle, fixed priority:
  - 1. clear sequencer
  - 2. CPU write to the RAM window (clears bit cpu_ad)
  - 3. CPU read of the RAM window
  - 4. queue drain (sets bit at queue head, pops)
- Queue drain: one entry per free cycle; oldest first.
- CPU RAM read:
  - cpu_dout[0] = RAM[cpu_ad] OR (any valid queue entry == cpu_ad), evaluated in the strobe cycle.
  - Registered, so valid 1 cycle after cpu_rd; held until the next read.
  - cpu_dout[7:1] = 7'h7F (open bus convention).
- CPU flag read: cpu_dout = {6'h3F, q_ovf, coll_flag}, same 1-cycle latency.
- CPU RAM write (clear):
  - Clears RAM[cpu_ad].
  - Invalidates every queue entry equal to cpu_ad that is already queued.
  - An sprcoll to the same address in the same cycle is enqueued after the clear and survives.
- CPU flag write:
  - Clears coll_flag and q_ovf.
  - A same-cycle sprcoll keeps coll_flag=1 (set wins).
  - A same-cycle overflow keeps q_ovf=1.
- Select and strobe rules:
  - Both selects active in one cycle: cpu_cs_flag wins; no RAM operation.
  - cpu_rd and cpu_wr together: the write wins; cpu_dout is unchanged.
- Simultaneous enqueue and drain while full: drain first, so the push succeeds (no overflow).
- Invalidated entries: still occupy queue slots and are popped without a RAM write.
- Queue pointers are log2(QDEPTH)+1 bits and wrap modulo 2*QDEPTH. Full/empty come from pointer MSB compare.

Test Plan:
- Reset, then wait 1024 cycles → RAM reads at 0x000, 0x3FF return 8'hFE; flag read returns 8'hFC.
- sprcoll at 0x155, then CPU read 0x155 two cycles later → cpu_dout=8'hFF; coll_flag=1; read 0x156 returns 8'hFE.
- CPU reads continuously while 3 sprcoll pulses arrive (0x010, 0x020, 0x030):
  - Reads of each address return D0=1 via queue bypass.
  - After reads stop, all three are in RAM within 3 cycles.
- Overflow:
  - Hold CPU reading while 6 distinct sprcoll addresses arrive (QDEPTH=4).
  - q_ovf=1; the first 4 addresses are recorded; flag read gives 8'hFF.
  - A flag write then gives 8'hFC.
- Coalescing: 5 back-to-back sprcoll at 0x200 while the CPU stalls drain → one queue entry; q_ovf stays 0.
- Clear races:
  - CPU write to 0x080 the same cycle sprcoll to 0x080 → bit reads 1.
  - CPU write to 0x090 while 0x090 is queued (no new hit) → bit reads 0.
  - Assert RESET_N low mid-drain → all outputs 0 immediately.
